uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLK_HZ, default 50000000, meaning: system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, meaning: serial bit rate; CLKS_PER_BIT = CLK_HZ/BAUD, integer-truncated, and SHALL be >= 4.
REQ-003 Parameter FIFO_DEPTH, default 4, meaning: number of receive FIFO entries; SHALL be a power of two, >= 2.
REQ-004 clk  input  1  system clock; all state updates on posedge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 rx  input  1  serial line; idle high; asynchronous to clk.
REQ-007 rd_ack  input  1  one-cycle pulse issued when the CPU load of address 0x13F4 completes; pops the FIFO.
REQ-008 uart_data  output  32  status/data word consumed by data memory at 0x13F4.
REQ-009 rx_irq  output  1  high while the FIFO is non-empty.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rx_s.
REQ-011 FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
REQ-012 IDLE -> START on a rx_s 1->0 transition; bit counter cleared.
REQ-013 START: at CLKS_PER_BIT/2 cycles, rx_s=0 -> DATA; rx_s=1 -> IDLE (false start, no flag).
REQ-014 DATA: sample rx_s every CLKS_PER_BIT cycles; 8 bits, LSB first; after bit 7 -> PARITY or STOP.
REQ-015 STOP: sample after CLKS_PER_BIT cycles; rx_s=1 -> push byte; rx_s=0 -> drop byte, set frame_err; both cases -> IDLE.
REQ-016 Push latency: byte visible in uart_data[7:0] on the cycle after the stop-bit sample edge if the FIFO was empty.
REQ-017 uart_data = {valid, overrun, frame_err, parity_err, 20'b0, head_byte}; valid = FIFO non-empty; head_byte = 8'h00 when empty.
REQ-018 rd_ack with FIFO non-empty: pop the head on that edge; rd_ack with FIFO empty: no pointer change.
REQ-019 rd_ack SHALL clear overrun, frame_err and parity_err on the same edge, regardless of FIFO state.
REQ-020 Push with FIFO full and no simultaneous pop: byte dropped, FIFO unchanged, overrun set.
REQ-021 Simultaneous push and pop: both occur, count unchanged, no overrun even when full.
REQ-022 Flag set and rd_ack clear on the same edge: set wins.
REQ-023 Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.

Reset
REQ-024 rst SHALL force FSM=IDLE, FIFO empty, pointers and counters 0, flags 0, synchronizer flops 1.
REQ-025 During reset: uart_data = 32'h0 and rx_irq = 0.
REQ-026 rst asserted mid-frame: the partial byte is discarded; after release, reception resumes only on the next falling edge.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: PARITY state samples an even-parity bit one CLKS_PER_BIT after bit 7; on mismatch, drop the byte and set parity_err; frame is 11 bits.
REQ-028 Macro UART_RX_PARITY_EN undefined: no PARITY state, frame is 10 bits, and uart_data[28] is constant 0.

Verification (CLK_HZ=16, BAUD=1, so CLKS_PER_BIT=16; FIFO_DEPTH=4)
REQ-029 Frame 0x41, valid stop -> uart_data=32'h80000041 and rx_irq=1; rd_ack -> uart_data=32'h00000000.
REQ-030 Five frames 0x01..0x05, no rd_ack -> uart_data=32'hC0000001; four rd_acks return 0x01..0x04, then valid=0.
REQ-031 Frame 0x55 with stop bit 0 -> FIFO stays empty and uart_data=32'h20000000; rd_ack -> 32'h0.
REQ-032 rx low for 4 cycles then high -> FSM returns to IDLE; no push and no flag.
REQ-033 FIFO full and rd_ack on the same edge as the fifth push -> count stays 4, overrun=0, new head is the second byte.
REQ-034 rst pulse during DATA bit 3 of 0xA5, then a clean frame 0x3C -> only 0x3C is received; with UART_RX_PARITY_EN, a bad parity bit gives uart_data=32'h10000000.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a small FIFO, exposed to the CPU as
// one memory-mapped status/data word. Define UART_RX_PARITY_EN to receive
// 8E1 frames with an even-parity check. Without it the frame is 10 bits.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        rd_ack,
    output logic [31:0] uart_data,
    output logic        rx_irq
);

    localparam int CPB  = CLK_HZ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state, state_nxt;
    logic            rx_meta, rx_s, rx_prev;
    logic [1:0]      arm;
    logic [CW-1:0]   clk_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            tick_half, tick_full;
    logic            shift_en, push_req, frame_set;
    logic            overrun, frame_err, parity_err;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] count;
    logic            valid, full, pop, do_push, ovr_set;
`ifdef UART_RX_PARITY_EN
    logic            parity_set, par_bad;
`endif

    assign tick_half = (clk_cnt == CW'(HALF - 1));
    assign tick_full = (clk_cnt == CW'(CPB - 1));

    // Two-flop synchronizer; rx_prev only trusts rx_s once the reset value
    // has flushed out, so a line held low across reset is not a fake edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b0;
            arm     <= 2'b00;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s & arm[1];
            arm     <= {arm[0], 1'b1};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (rx_prev && !rx_s) state_nxt = START;
            START: if (tick_half) state_nxt = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:   if (tick_full && bit_cnt == 3'd7) state_nxt = PARITY;
            PARITY: if (tick_full) state_nxt = STOP;
`else
            DATA:  if (tick_full && bit_cnt == 3'd7) state_nxt = STOP;
`endif
            STOP:  if (tick_full) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: data sample strobe, push request and error strobes.
    always_comb begin
        shift_en  = (state == DATA) && tick_full;
        frame_set = (state == STOP) && tick_full && !rx_s;
`ifdef UART_RX_PARITY_EN
        parity_set = (state == PARITY) && tick_full && (rx_s != ^shift);
        push_req   = (state == STOP) && tick_full && rx_s && !par_bad;
`else
        push_req   = (state == STOP) && tick_full && rx_s;
`endif
    end

    // Bit-period and bit-index counters; restart on every state change and sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_cnt <= '0;
            bit_cnt <= 3'd0;
        end else begin
            if (state == IDLE || state != state_nxt || shift_en) clk_cnt <= '0;
            else                                                 clk_cnt <= clk_cnt + 1'b1;
            if (state == IDLE)  bit_cnt <= 3'd0;
            else if (shift_en)  bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Receive shift register, LSB arrives first.
    always_ff @(posedge clk) begin
        if (shift_en) shift <= {rx_s, shift[7:1]};
    end

`ifdef UART_RX_PARITY_EN
    // Remember a parity failure so the stop bit does not push the byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 par_bad <= 1'b0;
        else if (state == IDLE)  par_bad <= 1'b0;
        else if (state == PARITY && tick_full) par_bad <= parity_set;
    end
`endif

    assign valid   = (count != '0);
    assign full    = (count == CNTW'(FIFO_DEPTH));
    assign pop     = rd_ack && valid;
    assign do_push = push_req && (!full || pop);
    assign ovr_set = push_req && full && !pop;

    // FIFO storage; a pop that frees a full slot lets the same-edge push land.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shift;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !pop)      count <= count + 1'b1;
            else if (pop && !do_push) count <= count - 1'b1;
        end
    end

    // Sticky error flags; a new error beats a same-edge read clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (ovr_set)     overrun <= 1'b1;
            else if (rd_ack) overrun <= 1'b0;
            if (frame_set)   frame_err <= 1'b1;
            else if (rd_ack) frame_err <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Sticky parity error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             parity_err <= 1'b0;
        else if (parity_set) parity_err <= 1'b1;
        else if (rd_ack)     parity_err <= 1'b0;
    end
`else
    assign parity_err = 1'b0;
`endif

    assign rx_irq    = valid;
    assign uart_data = {valid, overrun, frame_err, parity_err, 20'b0,
                        valid ? mem[rd_ptr] : 8'h00};

endmodule
